mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; legal range 4..64.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port port_a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port port_b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid that cycle.
REQ-011 SHALL have port hi  output  WIDTH  product upper half, or remainder.
REQ-012 SHALL have port lo  output  WIDTH  product lower half, or quotient.
REQ-013 SHALL have port div_zero  output  1  last completed divide had divisor 0.

Function
REQ-014 SHALL implement states IDLE, CALC, FIXUP, DONE, all registered.
REQ-015 SHALL, in IDLE with start=1 and flush=0, latch op and operands into internal registers.
- Signed ops latch absolute values and record the result signs.
- Go to CALC; load the iteration counter with WIDTH.
REQ-016 SHALL, in CALC, perform exactly one iteration per cycle and decrement the counter.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
- Go to FIXUP after WIDTH iterations.
REQ-017 SHALL, in FIXUP, apply the sign correction, write hi/lo, then go to DONE.
REQ-018 SHALL, in DONE, assert done=1 for that single cycle, then return to IDLE.
REQ-019 SHALL make latency fixed: start sampled at edge 0 gives done=1 in the cycle following edge WIDTH+2.
REQ-020 SHALL, for MULT/MULTU, place the full 2*WIDTH product in {hi,lo}.
- MULT treats operands as two's-complement; MULTU treats them as unsigned.
REQ-021 SHALL, for DIV, truncate the quotient toward zero (lo) and give the remainder the sign of the dividend (hi).
- DIVU is unsigned.
REQ-022 SHALL, for DIV of most-negative value by -1, give lo=most-negative value and hi=0, with no flag.
REQ-023 SHALL handle divisor 0 as follows:
- Skip CALC and FIXUP.
- Go IDLE->DONE with lo=all ones, hi=dividend, div_zero=1.
- done appears one cycle after start.
REQ-024 SHALL clear div_zero on every completion that is not a divide-by-zero.
REQ-025 SHALL ignore start while busy=1; latched operands and op SHALL not change mid-operation.
REQ-026 SHALL, on flush=1 in any state, go to IDLE next edge.
- done is not asserted.
- hi, lo and div_zero keep their previous values.
- flush overrides a simultaneous start.
REQ-027 SHALL hold hi, lo and div_zero stable between completions, independent of port_a, port_b and op.
REQ-028 SHALL allow back-to-back operations: start may be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-029 SHALL, on nRST low, immediately force state IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0, regardless of CLK.
REQ-030 SHALL discard any operation in progress on reset without asserting done.
REQ-031 SHALL accept start on the first rising edge after nRST deasserts.

Verification (WIDTH=32)
REQ-032 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start edge, busy high throughout.
REQ-033 SHALL cover: MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV -7/2 back-to-back -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL cover: DIVU 0x12345678/0 -> done one cycle after start, lo=0xFFFFFFFF, hi=0x12345678, div_zero=1; following DIVU 100/7 -> lo=14, hi=2, div_zero=0.
REQ-035 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-036 SHALL cover: start pulsed at cycle 5 of a running MULT -> ignored, original result returned; flush at cycle 10 of a DIV -> IDLE next edge, no done, hi/lo unchanged.
REQ-037 SHALL cover: nRST asserted mid-CALC between clock edges -> outputs zero immediately; after release, MULTU 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one
// bit per clock, with sign handling done on magnitudes before and after.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic             is_div_q;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [CW-1:0]    count;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_by_zero;
    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // op[0] clear selects the signed variant of both MULT and DIV.
    assign a_neg       = ~op[0] & port_a[WIDTH-1];
    assign b_neg       = ~op[0] & port_b[WIDTH-1];
    assign abs_a       = a_neg ? -port_a : port_a;
    assign abs_b       = b_neg ? -port_b : port_b;
    assign div_by_zero = op[1] && (port_b == '0);

    assign mult_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    always_comb begin
        prod_fix = {work_hi, work_lo};
        if (neg_res) begin
            prod_fix = -{work_hi, work_lo};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) state_next = div_by_zero ? DONE : CALC;
                // The cycle in which the counter reads zero hands over to FIXUP.
                CALC:  if (count == '0) state_next = FIXUP;
                FIXUP: state_next = DONE;
                DONE:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            opb_q    <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        opb_q    <= abs_b;
                        work_hi  <= '0;
                        work_lo  <= abs_a;
                        if (div_by_zero) begin
                            hi       <= port_a;
                            lo       <= '1;
                            div_zero <= 1'b1;
                            count    <= '0;
                        end else begin
                            count <= CW'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                        if (is_div_q) begin
                            if (!div_diff[WIDTH]) begin
                                work_hi <= div_diff[WIDTH-1:0];
                            end else begin
                                work_hi <= div_shift[WIDTH-1:0];
                            end
                            work_lo <= {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                        end else begin
                            work_hi <= mult_sum[WIDTH:1];
                            work_lo <= {mult_sum[0], work_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIXUP: begin
                    div_zero <= 1'b0;
                    if (is_div_q) begin
                        lo <= neg_res ? -work_lo : work_lo;
                        hi <= neg_rem ? -work_hi : work_hi;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus randomized operations
// checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    localparam int W     = 32;
    localparam int LAT   = W + 2;
    localparam int LIMIT = 200;

    logic         CLK = 1'b0;
    logic         nRST = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] port_a = '0;
    logic [W-1:0] port_b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Last completed result as predicted by the model.
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;
    logic [2*W:0] exp_q[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .port_a(port_a), .port_b(port_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_zero(div_zero), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {div_zero, hi, lo}.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [2*W-1:0]  res;
        logic            dz;
        dz = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        res = '0;
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (b == '0) begin
                    dz  = 1'b1;
                    res = {a, {W{1'b1}}};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[W-1:0], q[W-1:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[W-1:0], uq[W-1:0]};
                end
            end
        endcase
        return {dz, res};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle following completion, ready for a back-to-back request.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] rh, output logic [W-1:0] rl,
                         output logic rdz, output logic busy_ok, output logic pulse_ok);
        start = 1'b1; op = o; port_a = a; port_b = b;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; op = 2'($urandom); port_a = W'($urandom); port_b = W'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < LIMIT) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge CLK);
            lat++;
        end
        rh = hi; rl = lo; rdz = div_zero;
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(negedge CLK);
        pulse_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #12;
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/div_zero=%b required 000", {busy, done, div_zero});
        end
        checks++;
        if ({hi, lo} !== '0) begin
            errors++;
            $display("FAIL reset_data: hi=%h lo=%h required 0/0", hi, lo);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_multu_max();
        int lat; logic [W-1:0] rh, rl; logic rdz, bok, pok;
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rh, rl, rdz, bok, pok);
        {exp_dz, exp_hi, exp_lo} = model(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if ({rh, rl} !== {32'hFFFFFFFE, 32'h00000001}) begin
            errors++;
            $display("FAIL multu_max: hi=%h lo=%h required fffffffe/00000001", rh, rl);
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL multu_latency: %0d required %0d", lat, LAT);
        end
        checks++;
        if (!bok || !pok) begin
            errors++;
            $display("FAIL multu_busy_pulse: busy_ok=%b pulse_ok=%b required 1/1", bok, pok);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [W-1:0] rh, rl; logic rdz, bok, pok;
        do_op(2'b00, -32'sd3, 32'd5, lat, rh, rl, rdz, bok, pok);
        checks++;
        if ({rh, rl} !== {32'hFFFFFFFF, 32'hFFFFFFF1}) begin
            errors++;
            $display("FAIL mult_neg: hi=%h lo=%h required ffffffff/fffffff1", rh, rl);
        end
        do_op(2'b10, -32'sd7, 32'd2, lat, rh, rl, rdz, bok, pok);
        {exp_dz, exp_hi, exp_lo} = model(2'b10, -32'sd7, 32'd2);
        checks++;
        if ({rh, rl, rdz} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin
            errors++;
            $display("FAIL div_b2b: hi=%h lo=%h dz=%b required ffffffff/fffffffd/0", rh, rl, rdz);
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL div_b2b_latency: %0d required %0d", lat, LAT);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [W-1:0] rh, rl; logic rdz, bok, pok;
        do_op(2'b11, 32'h12345678, 32'd0, lat, rh, rl, rdz, bok, pok);
        checks++;
        if ({rh, rl, rdz} !== {32'h12345678, 32'hFFFFFFFF, 1'b1}) begin
            errors++;
            $display("FAIL divu_zero: hi=%h lo=%h dz=%b required 12345678/ffffffff/1", rh, rl, rdz);
        end
        checks++;
        if (lat != 0 || !pok) begin
            errors++;
            $display("FAIL divu_zero_latency: %0d pulse_ok=%b required 0/1", lat, pok);
        end
        do_op(2'b11, 32'd100, 32'd7, lat, rh, rl, rdz, bok, pok);
        {exp_dz, exp_hi, exp_lo} = model(2'b11, 32'd100, 32'd7);
        checks++;
        if ({rh, rl, rdz} !== {32'd2, 32'd14, 1'b0}) begin
            errors++;
            $display("FAIL divu_after_zero: hi=%0d lo=%0d dz=%b required 2/14/0", rh, rl, rdz);
        end
    endtask

    task automatic test_div_overflow();
        int lat; logic [W-1:0] rh, rl; logic rdz, bok, pok;
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, rh, rl, rdz, bok, pok);
        {exp_dz, exp_hi, exp_lo} = model(2'b10, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if ({rh, rl, rdz} !== {32'h0, 32'h80000000, 1'b0}) begin
            errors++;
            $display("FAIL div_min_by_m1: hi=%h lo=%h dz=%b required 0/80000000/0", rh, rl, rdz);
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] a, b;
        int n;
        a = W'($urandom); b = W'($urandom);
        start = 1'b1; op = 2'b00; port_a = a; port_b = b;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (!done && n < LIMIT) begin
            if (n == 5) begin
                start = 1'b1; op = 2'b11; port_a = W'($urandom); port_b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        start = 1'b0;
        {exp_dz, exp_hi, exp_lo} = model(2'b00, a, b);
        checks++;
        if ({div_zero, hi, lo} !== {exp_dz, exp_hi, exp_lo} || n != LAT) begin
            errors++;
            $display("FAIL start_ignored: hi=%h lo=%h dz=%b lat=%0d required %h/%h/%b/%0d",
                     hi, lo, div_zero, n, exp_hi, exp_lo, exp_dz, LAT);
        end
        @(negedge CLK);
    endtask

    task automatic test_flush();
        int seen;
        start = 1'b1; op = 2'b10; port_a = W'($urandom); port_b = W'($urandom_range(1, 1000));
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b done=%b required 0/0", busy, done);
        end
        seen = 0;
        repeat (40) begin
            if (done === 1'b1) seen++;
            @(negedge CLK);
        end
        checks++;
        if (seen != 0 || {div_zero, hi, lo} !== {exp_dz, exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL flush_hold: done_seen=%0d hi=%h lo=%h dz=%b required 0/%h/%h/%b",
                     seen, hi, lo, div_zero, exp_hi, exp_lo, exp_dz);
        end
        start = 1'b1; flush = 1'b1; op = 2'b01;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] rh, rl; logic rdz, bok, pok;
        int seen;
        start = 1'b1; op = 2'b01; port_a = W'($urandom); port_b = W'($urandom);
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_zero, hi, lo} !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b dz=%b hi=%h lo=%h required all 0",
                     busy, done, div_zero, hi, lo);
        end
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        nRST = 1'b1;
        do_op(2'b01, 32'd6, 32'd7, lat, rh, rl, rdz, bok, pok);
        {exp_dz, exp_hi, exp_lo} = model(2'b01, 32'd6, 32'd7);
        checks++;
        if ({rh, rl} !== {32'd0, 32'd42} || lat != LAT || seen != 0) begin
            errors++;
            $display("FAIL reset_then_multu: hi=%0d lo=%0d lat=%0d activity=%0d required 0/42/%0d/0",
                     rh, rl, lat, seen, LAT);
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] rh, rl; logic rdz, bok, pok;
        logic [1:0] o; logic [W-1:0] a, b;
        logic [2*W:0] e;
        int exp_lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            exp_q.push_back(model(o, a, b));
            exp_lat = (o[1] && b == '0) ? 0 : LAT;
            do_op(o, a, b, lat, rh, rl, rdz, bok, pok);
            e = exp_q.pop_front();
            {exp_dz, exp_hi, exp_lo} = e;
            checks++;
            if ({rdz, rh, rl} !== e || lat != exp_lat || !bok || !pok) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %b/%h/%h lat=%0d bok=%b pok=%b required %b/%h/%h lat=%0d",
                         i, o, a, b, rdz, rh, rl, lat, bok, pok, exp_dz, exp_hi, exp_lo, exp_lat);
            end
            checks++;
            if ({div_zero, hi, lo} !== e) begin
                errors++;
                $display("FAIL random_hold_%0d: got %b/%h/%h required %b/%h/%h",
                         i, div_zero, hi, lo, exp_dz, exp_hi, exp_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_zero();
        test_div_overflow();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
